// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: multi-cycle MULT/DIV sequencer for the EX stage.
// It owns HI/LO, runs a fixed-length busy window per operation and raises
// md_stall so the hazard logic can hold dependent instructions in ID.
module md_unit_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // Counter width covers the longer of the two busy windows (loads N-1).
    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q;
    logic [31:0]       a_q, b_q;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;

    logic              accept;
    logic              commit;

    // MULT/MULTU/DIV/DIVU are the codes with bit 2 clear; only they start a window.
    assign accept = start && (state_q == S_IDLE) && !md_op[2];
    assign commit = (state_q == S_RUN) && (cnt_q == '0);

    // ------------------------------------------------------------------
    // Arithmetic on the latched operands only. Bit 0 of the op selects
    // unsigned, bit 1 selects divide (MULT=0, MULTU=1, DIV=2, DIVU=3).
    // ------------------------------------------------------------------
    logic        op_signed;
    logic        op_is_div;
    logic [63:0] mul_a, mul_b, prod;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [31:0] q_mag, r_mag;
    logic [31:0] quot, rem;
    logic        div_by_zero;

    // Product, magnitude divide and sign fix-up for the operation in flight.
    always_comb begin
        op_signed   = !op_q[0];
        op_is_div   = op_q[1];

        // Sign-extending to 64 bits makes the low 64 product bits correct
        // for signed operands, so one multiplier serves both MULT flavours.
        mul_a = {{32{op_signed & a_q[31]}}, a_q};
        mul_b = {{32{op_signed & b_q[31]}}, b_q};
        prod  = mul_a * mul_b;

        a_neg = op_signed & a_q[31];
        b_neg = op_signed & b_q[31];
        a_mag = a_neg ? (~a_q + 32'd1) : a_q;
        b_mag = b_neg ? (~b_q + 32'd1) : b_q;

        div_by_zero = (b_q == 32'd0);
        if (div_by_zero) begin
            q_mag = 32'd0;
            r_mag = 32'd0;
        end else begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end

        // Quotient truncates toward zero; remainder takes the dividend sign.
        // 0x80000000 / -1 wraps back to 0x80000000 with remainder 0.
        quot = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem  = a_neg ? (~r_mag + 32'd1) : r_mag;
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a MULT/DIV opens a window; cnt==0 in RUN closes it.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (accept) state_d = S_RUN;
            S_RUN:  if (cnt_q == '0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: busy follows RUN; stall covers the issue cycle too.
    always_comb begin
        busy     = (state_q == S_RUN);
        md_stall = start | busy;
        hi       = hi_q;
        lo       = lo_q;
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------

    // Window counter: load N-1 on accept, count down while running.
    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = md_op[1] ? DIV_LOAD : MULT_LOAD;
        end else if ((state_q == S_RUN) && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // HI/LO update: direct moves only while idle, results only at commit.
    // Moves arriving during RUN are dropped; the hazard unit prevents them.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (state_q == S_IDLE) begin
            if (start && (md_op == OP_MTHI)) hi_d = rs_val;
            if (start && (md_op == OP_MTLO)) lo_d = rs_val;
        end else if (commit) begin
            if (op_is_div) begin
                if (!div_by_zero) begin
                    hi_d = rem;
                    lo_d = quot;
                end
            end else begin
                hi_d = prod[63:32];
                lo_d = prod[31:0];
            end
        end
    end

    // Counter and HI/LO registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            hi_q  <= 32'd0;
            lo_q  <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end

    // Operand/op capture on accept so the forwarded buses may change in RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q <= 3'd0;
            a_q  <= 32'd0;
            b_q  <= 32'd0;
        end else if (accept) begin
            op_q <= md_op;
            a_q  <= rs_val;
            b_q  <= rt_val;
        end
    end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Directed bench for md_unit_ctrl: busy-window length, HI/LO results,
// operand isolation during RUN, ignored moves, and async reset abort.
module tb_md_unit_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int passes;

    md_unit_ctrl #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .md_op   (md_op),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .busy    (busy),
        .md_stall(md_stall),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs === exp) begin
            passes++;
            $display("ok   %-16s got %h", tag, obs);
        end else begin
            $display("FAIL %-16s got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op for a single cycle; called at a falling edge, returns at the next one.
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        md_op  = op;
        rs_val = a;
        rt_val = b;
        #1;
        chk("stall_on_start", {31'd0, md_stall}, 32'd1);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count busy cycles then check HI/LO. mode 1 zeroes the operand buses
    // mid-run, mode 2 injects an MTLO mid-run.
    task automatic wait_done(input string tag, input int exp_n, input int mode,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        int stall_bad;
        n = 0;
        stall_bad = 0;
        while (busy === 1'b1 && n < 50) begin
            if (md_stall !== 1'b1) stall_bad++;
            if (mode == 1 && n == 1) begin
                rs_val = 32'd0;
                rt_val = 32'd0;
            end
            if (mode == 2 && n == 2) begin
                start  = 1'b1;
                md_op  = 3'd5;
                rs_val = 32'h0000dead;
            end
            @(negedge clk);
            start = 1'b0;
            n++;
        end
        chk({tag, "_cycles"}, n, exp_n);
        chk({tag, "_stall"}, stall_bad, 32'd0);
        chk({tag, "_hi"}, hi, exp_hi);
        chk({tag, "_lo"}, lo, exp_lo);
    endtask

    // Single-cycle MTHI/MTLO/reserved op while idle.
    task automatic mt(input string tag, input logic [2:0] op, input logic [31:0] v,
                      input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        start  = 1'b1;
        md_op  = op;
        rs_val = v;
        @(posedge clk);
        #1;
        chk({tag, "_hi"}, hi, exp_hi);
        chk({tag, "_lo"}, lo, exp_lo);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk({tag, "_stall0"}, {31'd0, md_stall}, 32'd0);
    endtask

    initial begin
        checks = 0;
        passes = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        md_op  = 3'd0;
        rs_val = 32'd0;
        rt_val = 32'd0;

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_stall", {31'd0, md_stall}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);

        // Preload HI/LO so the mid-run reset has something to clear.
        mt("mthi_pre", 3'd4, 32'h0000aaaa, 32'h0000aaaa, 32'd0);
        mt("mtlo_pre", 3'd5, 32'h00005555, 32'h0000aaaa, 32'h00005555);

        // Reset asserted in the middle of a MULT.
        start_op(3'd0, 32'd6, 32'd7);
        @(negedge clk);
        chk("midrun_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_hi", hi, 32'd0);
        chk("post_rst_lo", lo, 32'd0);

        // MULT -2*3 and MULTU 0xFFFFFFFE*3.
        start_op(3'd0, 32'hFFFFFFFE, 32'd3);
        wait_done("mult", 5, 0, 32'hFFFFFFFF, 32'hFFFFFFFA);
        start_op(3'd1, 32'hFFFFFFFE, 32'd3);
        wait_done("multu", 5, 0, 32'h00000002, 32'hFFFFFFFA);

        // DIV -7/2, DIVU by zero, DIV 7/-2, DIV overflow case.
        start_op(3'd2, 32'hFFFFFFF9, 32'd2);
        wait_done("div_neg", 10, 0, 32'hFFFFFFFF, 32'hFFFFFFFD);
        start_op(3'd3, 32'd7, 32'd0);
        wait_done("divu_zero", 10, 0, 32'hFFFFFFFF, 32'hFFFFFFFD);
        start_op(3'd2, 32'd7, 32'hFFFFFFFE);
        wait_done("div_negdvs", 10, 0, 32'h00000001, 32'hFFFFFFFD);
        start_op(3'd2, 32'h80000000, 32'hFFFFFFFF);
        wait_done("div_ovf", 10, 0, 32'h00000000, 32'h80000000);

        // Operand buses zeroed during RUN must not disturb the result.
        start_op(3'd0, 32'd6, 32'd7);
        wait_done("opchg", 5, 1, 32'd0, 32'd42);

        // MTHI while idle, then a reserved op that must do nothing.
        mt("mthi", 3'd4, 32'h00001234, 32'h00001234, 32'd42);
        mt("reserved", 3'd6, 32'h0000beef, 32'h00001234, 32'd42);

        // MTLO injected during RUN is ignored.
        start_op(3'd0, 32'd5, 32'd5);
        wait_done("mtlo_run", 5, 2, 32'd0, 32'd25);

        // Back-to-back: MULTU issued in the first idle cycle after DIVU commits.
        start_op(3'd3, 32'd100, 32'd7);
        wait_done("b2b_divu", 10, 0, 32'd2, 32'd14);
        start_op(3'd1, 32'd3, 32'd4);
        wait_done("b2b_multu", 5, 0, 32'd0, 32'd12);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
